cla_pipe_adder: RTL

- Parametrised, two-stage pipelined carry-lookahead adder/subtractor. Successor to the team's fixed 4-bit combinational CLA.
- Splits WIDTH into GROUP-bit lookahead groups: stage 1 computes group propagate/generate, stage 2 resolves inter-group carries and the sum.
- Valid/ready handshake on both sides. Sits in datapaths that need full-throughput add/sub with backpressure.

---
 rtl/cla_pipe_adder.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// cla_pipe_adder
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready
// handshake on both sides and a sideband tag that travels with each op.
//   Stage 1 registers the operands, the effective B operand, the carry-in and
//   the per-group propagate/generate terms.
//   Stage 2 resolves the inter-group carries with a flat lookahead, forms the
//   bit sums and registers sum/cout/ovf/zero/out_tag.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   input handshake
//   a, b, cin, sub        operands; sub=1 computes a-b and ignores cin
//   in_tag / out_tag      sideband tag, returned unchanged
//   out_valid / out_ready output handshake
//   sum, cout, ovf, zero  result, carry-out (no-borrow for sub), signed
//                         overflow, sum==0
// ---------------------------------------------------------------------------
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NG = WIDTH / GROUP;

  generate
    if ((WIDTH % GROUP) != 0 || GROUP < 2 || GROUP > 8 || WIDTH < GROUP || TAG_W < 1) begin : g_bad_params
      $error("cla_pipe_adder: illegal WIDTH/GROUP/TAG_W combination");
    end
  endgenerate

  // ---------------- handshake ----------------
  logic s1_valid_q;
  logic out_valid_q;
  logic adv2_s, adv1_s, acc_s, ld2_s;

  assign adv2_s   = ~out_valid_q | out_ready;
  assign adv1_s   = ~s1_valid_q | adv2_s;
  assign acc_s    = in_valid & adv1_s;
  assign ld2_s    = s1_valid_q & adv2_s;
  assign in_ready = adv1_s;

  // ---------------- stage 1 combinational ----------------
  logic [WIDTH-1:0] b_eff_s;
  logic             c0_s;
  logic [WIDTH-1:0] p1_s, g1_s;
  logic [NG-1:0]    gp_d, gg_d;

  assign b_eff_s = sub ? ~b : b;
  assign c0_s    = sub ? 1'b1 : cin;
  assign p1_s    = a ^ b_eff_s;
  assign g1_s    = a & b_eff_s;

  // Group propagate (AND of bit propagates) and group generate (in-group chain)
  always_comb begin
    gp_d = '1;
    gg_d = '0;
    for (int k = 0; k < NG; k++) begin
      for (int j = 0; j < GROUP; j++) begin
        gp_d[k] = gp_d[k] & p1_s[k*GROUP+j];
        gg_d[k] = g1_s[k*GROUP+j] | (p1_s[k*GROUP+j] & gg_d[k]);
      end
    end
  end

  // ---------------- stage 1 registers ----------------
  // sub is not kept: it is fully folded into b_eff_q and c0_q.
  logic [WIDTH-1:0] a_q, b_eff_q;
  logic             c0_q;
  logic [TAG_W-1:0] tag_q;
  logic [NG-1:0]    gp_q, gg_q;

  // Stage-1 valid and operand/lookahead registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_eff_q    <= '0;
      c0_q       <= 1'b0;
      tag_q      <= '0;
      gp_q       <= '0;
      gg_q       <= '0;
    end else begin
      s1_valid_q <= acc_s | (s1_valid_q & ~adv2_s);
      if (acc_s) begin
        a_q     <= a;
        b_eff_q <= b_eff_s;
        c0_q    <= c0_s;
        tag_q   <= in_tag;
        gp_q    <= gp_d;
        gg_q    <= gg_d;
      end
    end
  end

  // ---------------- stage 2 combinational ----------------
  logic [WIDTH-1:0] p2_s, g2_s;
  logic [NG:0]      gc_s;     // group carry-ins, gc_s[NG] is carry out of MSB
  logic [WIDTH-1:0] bc_s;     // per-bit carry-ins
  logic [WIDTH-1:0] sum_d;
  logic             cout_d, ovf_d, zero_d;
  logic             term_s, prod_s, chain_s;

  assign p2_s = a_q ^ b_eff_q;
  assign g2_s = a_q & b_eff_q;

  // Flat lookahead: C[k+1] = c0&P0..Pk | OR_j (G_j & P_{j+1}..P_k)
  always_comb begin
    gc_s    = '0;
    gc_s[0] = c0_q;
    term_s  = 1'b0;
    prod_s  = 1'b0;
    for (int k = 0; k < NG; k++) begin
      term_s = c0_q;
      for (int m = 0; m <= k; m++) begin
        term_s = term_s & gp_q[m];
      end
      for (int j = 0; j <= k; j++) begin
        prod_s = gg_q[j];
        for (int m = j + 1; m <= k; m++) begin
          prod_s = prod_s & gp_q[m];
        end
        term_s = term_s | prod_s;
      end
      gc_s[k+1] = term_s;
    end
  end

  // In-group bit carries seeded from each group's carry-in, then bit sums
  always_comb begin
    bc_s    = '0;
    chain_s = 1'b0;
    for (int k = 0; k < NG; k++) begin
      chain_s = gc_s[k];
      for (int j = 0; j < GROUP; j++) begin
        bc_s[k*GROUP+j] = chain_s;
        chain_s = g2_s[k*GROUP+j] | (p2_s[k*GROUP+j] & chain_s);
      end
    end
  end

  assign sum_d  = p2_s ^ bc_s;
  assign cout_d = gc_s[NG];
  assign ovf_d  = bc_s[WIDTH-1] ^ gc_s[NG];
  assign zero_d = ~|sum_d;

  // ---------------- stage 2 registers ----------------
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q, zero_q;
  logic [TAG_W-1:0] out_tag_q;

  // Output valid and result registers; results hold while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_tag_q   <= '0;
    end else begin
      out_valid_q <= ld2_s | (out_valid_q & ~out_ready);
      if (ld2_s) begin
        sum_q     <= sum_d;
        cout_q    <= cout_d;
        ovf_q     <= ovf_d;
        zero_q    <= zero_d;
        out_tag_q <= tag_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign out_tag   = out_tag_q;

endmodule
